// File: rtl/gave_coord_pkg.sv
// Shared definitions for the GAVE coordinate-ready interrupt controller:
// register map, debounce state encoding and edge-selection codes.
package gave_coord_pkg;

  localparam logic [1:0] ADDR_LEVEL   = 2'd0;
  localparam logic [1:0] ADDR_COUNT   = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    QUAL_HI = 2'd1,
    ST_HI   = 2'd2,
    QUAL_LO = 2'd3
  } deb_state_t;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/gave_coord_debounce.sv
// Synchroniser plus debounce FSM for the raw coordinate-ready line.
// Produces a registered debounced level and one-cycle rise/fall pulses.
module gave_coord_debounce
  import gave_coord_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_port,
  output logic level,
  output logic rise,
  output logic fall
);

  // A single-cycle debounce still needs a one-bit counter to keep slices legal.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_t             state;
  logic [CW-1:0]          cnt;

  // Metastability synchroniser: shift the asynchronous line through SYNC_STAGES flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES stable samples;
  // level/rise/fall are registered so downstream logic sees clean signals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_LO: begin
          if (s) begin
            state <= QUAL_HI;
            cnt   <= '0;
          end
        end
        QUAL_HI: begin
          if (!s) begin
            state <= ST_LO;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HI;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HI: begin
          if (!s) begin
            state <= QUAL_LO;
            cnt   <= '0;
          end
        end
        QUAL_LO: begin
          if (s) begin
            state <= ST_HI;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LO;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_LO;
      endcase
    end
  end

endmodule

// File: rtl/gave_coord_irq_ctrl.sv
// Avalon-MM slave for the GAVE coordinate-ready line: sticky capture flag,
// saturating event counter, interrupt mask and a registered read port.
module gave_coord_irq_ctrl
  import gave_coord_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq,
  output logic        coord_level
);

  logic             level, rise, fall, evt;
  logic             wr_sel, rd_sel;
  logic             capture_q, mask_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  gave_coord_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .in_port(in_port),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign evt = (EDGE_MODE == EDGE_BOTH) ? (rise | fall) :
               (EDGE_MODE == EDGE_FALL) ? fall : rise;

  assign wr_sel       = chipselect & write;
  assign rd_sel       = chipselect & read;
  assign unused_wdata = ^writedata[31:1];

  // Sticky capture: an event in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                  capture_q <= 1'b0;
    else if (evt)                                               capture_q <= 1'b1;
    else if (wr_sel && address == ADDR_CAPTURE && writedata[0]) capture_q <= 1'b0;
  end

  // Event counter: cleared by any COUNT write (to 1 if an event lands that cycle), saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               count_q <= '0;
    else if (wr_sel && address == ADDR_COUNT) count_q <= evt ? CNT_W'(1) : '0;
    else if (evt && count_q != '1)           count_q <= count_q + 1'b1;
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               mask_q <= 1'b0;
    else if (wr_sel && address == ADDR_MASK) mask_q <= writedata[0];
  end

  // Read mux: unused bits read as zero, counter zero-extended.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_LEVEL:   rd_mux = {31'b0, level};
      ADDR_COUNT:   rd_mux = 32'(count_q);
      ADDR_MASK:    rd_mux = {31'b0, mask_q};
      ADDR_CAPTURE: rd_mux = {31'b0, capture_q};
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       readdata <= '0;
    else if (rd_sel) readdata <= rd_mux;
  end

  assign irq         = capture_q & mask_q;
  assign coord_level = level;

endmodule
